// File: rtl/ring_reader_pkg.sv
`default_nettype none
// ============================================================================
// ring_reader_pkg : FSM state encoding shared by the ring reader block
// Revision 1.0
// ============================================================================
package ring_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_LATCH   = 2'd2,
    ST_PRESENT = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ring_rd_pos.sv
`default_nettype none
// ============================================================================
// ring_rd_pos : ring read-position counter, wraps from ARRAY_SIZE-1 to 0
// Revision 1.0
// ============================================================================
module ring_rd_pos #(
  parameter int POS_BITS   = 3,
  parameter int ARRAY_SIZE = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                en_i,
  output logic [POS_BITS-1:0] pos_o
);

  localparam logic [POS_BITS-1:0] C_LAST = POS_BITS'(ARRAY_SIZE - 1);

  logic [POS_BITS-1:0] pos_q;
  logic [POS_BITS-1:0] pos_d;

  // Clear has priority so a new readout always starts from entry 0
  always_comb begin
    pos_d = pos_q;
    if (clr_i) begin
      pos_d = '0;
    end else if (en_i) begin
      pos_d = (pos_q == C_LAST) ? '0 : pos_q + POS_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos_o = pos_q;

endmodule
`default_nettype wire

// File: rtl/ring_reader.sv
`default_nettype none
// ============================================================================
// ring_reader : reads ring entries from an external synchronous RAM and
//               presents them one at a time over a valid/ready interface
// Revision 1.0
// ============================================================================
module ring_reader
  import ring_reader_pkg::*;
#(
  parameter int POS_BITS   = 3,
  parameter int ARRAY_SIZE = 5,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [POS_BITS-1:0]  wr_pos,
  output logic [POS_BITS-1:0]  rd_addr,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic [POS_BITS-1:0]  rd_pos,
  output logic                 busy,
  output logic                 empty
);

  state_e               state_q;
  logic [DATA_BITS-1:0] out_data_q;
  logic                 stop_pending_q;
  logic                 pos_clr;
  logic                 pos_adv;

  assign pos_clr = (state_q == ST_IDLE) && start && !stop;
  assign pos_adv = (state_q == ST_PRESENT) && out_ready;

  ring_rd_pos #(
    .POS_BITS   (POS_BITS),
    .ARRAY_SIZE (ARRAY_SIZE)
  ) u_rd_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (pos_clr),
    .en_i  (pos_adv),
    .pos_o (rd_pos)
  );

  assign rd_addr = rd_pos;
  assign empty   = (rd_pos == wr_pos);

  // rd_data is valid in LATCH because rd_addr was already stable through FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      out_data_q     <= '0;
      stop_pending_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (!empty) begin
            state_q <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else begin
            out_data_q <= rd_data;
            state_q    <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          // A stop arriving with the handshake itself ends the readout too
          if (out_ready) begin
            state_q        <= (stop_pending_q || stop) ? ST_IDLE : ST_FETCH;
            stop_pending_q <= 1'b0;
          end else if (stop) begin
            stop_pending_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = (state_q == ST_PRESENT);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_reader.sv
`default_nettype none
// ============================================================================
// tb_ring_reader : directed self-checking bench for ring_reader
// Revision 1.0
// ============================================================================
module tb_ring_reader;

  localparam int POS_BITS   = 3;
  localparam int ARRAY_SIZE = 5;
  localparam int DATA_BITS  = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 stop;
  logic [POS_BITS-1:0]  wr_pos;
  logic [POS_BITS-1:0]  rd_addr;
  logic [DATA_BITS-1:0] rd_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_data;
  logic [POS_BITS-1:0]  rd_pos;
  logic                 busy;
  logic                 empty;

  int n_checks;
  int n_fail;

  ring_reader #(
    .POS_BITS   (POS_BITS),
    .ARRAY_SIZE (ARRAY_SIZE),
    .DATA_BITS  (DATA_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .wr_pos    (wr_pos),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .rd_pos    (rd_pos),
    .busy      (busy),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM with contents RAM[i] = 8'h10 + i
  always_ff @(posedge clk) begin
    rd_data <= 8'h10 + DATA_BITS'(rd_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 8) begin
      step();
      lat++;
    end
    if (!out_valid) check_eq({tag, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    automatic int lat;
    automatic logic [7:0] wrap_seq [7] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h10, 8'h11};
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    wr_pos    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy",  32'(busy),      32'd0);
    check_eq("rst_pos",   32'(rd_pos),    32'd0);
    check_eq("rst_data",  32'(out_data),  32'd0);
    rst_n = 1'b1;
    step();

    // Basic readout of three entries
    wr_pos    = 3'd3;
    out_ready = 1'b1;
    pulse_start();
    check_eq("basic_busy", 32'(busy),   32'd1);
    check_eq("basic_pos0", 32'(rd_pos), 32'd0);
    for (int i = 0; i < 3; i++) begin
      wait_valid("basic", lat);
      check_eq("basic_lat",  32'(lat),      32'd2);
      check_eq("basic_data", 32'(out_data), 32'(8'h10 + i));
      step();
    end
    check_eq("basic_pos3",  32'(rd_pos),    32'd3);
    check_eq("basic_empty", 32'(empty),     32'd1);
    step();
    step();
    check_eq("basic_novalid", 32'(out_valid), 32'd0);
    check_eq("basic_fetch",   32'(busy),      32'd1);
    pulse_stop();
    check_eq("fetch_stop", 32'(busy), 32'd0);

    // Wrap: writer runs ahead and wraps to position 2
    wr_pos = 3'd4;
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      if (i == 3) wr_pos = 3'd2;
      wait_valid("wrap", lat);
      check_eq("wrap_data", 32'(out_data), 32'(wrap_seq[i]));
      if (i == 4) check_eq("wrap_pos4", 32'(rd_pos), 32'd4);
      step();
      if (i == 4) check_eq("wrap_pos0", 32'(rd_pos), 32'd0);
    end
    step();
    check_eq("wrap_empty", 32'(out_valid), 32'd0);
    pulse_stop();

    // Stop in IDLE ignored; start together with stop loses
    pulse_stop();
    check_eq("idle_stop", 32'(busy), 32'd0);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check_eq("startstop_busy", 32'(busy),   32'd0);
    check_eq("startstop_pos",  32'(rd_pos), 32'd2);

    // Backpressure with writer moving during PRESENT
    wr_pos    = 3'd1;
    out_ready = 1'b0;
    pulse_start();
    wait_valid("bp", lat);
    check_eq("bp_lat", 32'(lat), 32'd2);
    wr_pos = 3'd0;
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_data",  32'(out_data),  32'h10);
      check_eq("bp_pos",   32'(rd_pos),    32'd0);
    end
    wr_pos    = 3'd3;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("bp_adv",     32'(rd_pos),    32'd1);
    check_eq("bp_dropped", 32'(out_valid), 32'd0);

    // Stop pending while presenting entry at position 1
    wait_valid("sp", lat);
    check_eq("sp_data", 32'(out_data), 32'h11);
    pulse_start();
    check_eq("busy_start_pos",   32'(rd_pos),    32'd1);
    check_eq("busy_start_valid", 32'(out_valid), 32'd1);
    pulse_stop();
    check_eq("sp_still_valid", 32'(out_valid), 32'd1);
    check_eq("sp_still_data",  32'(out_data),  32'h11);
    step();
    out_ready = 1'b1;
    step();
    check_eq("sp_idle",    32'(busy),      32'd0);
    check_eq("sp_pos",     32'(rd_pos),    32'd2);
    check_eq("sp_novalid", 32'(out_valid), 32'd0);

    // Reset asserted while in LATCH
    wr_pos = 3'd4;
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      wait_valid("rl", lat);
      check_eq("rl_data", 32'(out_data), 32'(8'h10 + i));
      step();
    end
    step();
    check_eq("rl_latch_busy",  32'(busy),      32'd1);
    check_eq("rl_latch_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("rl_busy",  32'(busy),      32'd0);
    check_eq("rl_pos",   32'(rd_pos),    32'd0);
    check_eq("rl_valid", 32'(out_valid), 32'd0);
    check_eq("rl_data0", 32'(out_data),  32'd0);
    step();
    rst_n = 1'b1;
    pulse_start();
    wait_valid("post_rst", lat);
    check_eq("post_rst_data", 32'(out_data), 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire

// File: doc/ring_reader.md
RING_READER -- requirements
Module: ring_reader

Interface
REQ-001 Parameter POS_BITS, default 3: width of read/write position.
REQ-002 Parameter ARRAY_SIZE, default 5: number of entries in the ring; ARRAY_SIZE <= 2**POS_BITS.
REQ-003 Parameter DATA_BITS, default 8: entry width.
REQ-004 Port clk  input  1: sole clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1: asynchronous, active-low reset.
REQ-006 Port start  input  1: one-cycle pulse; begin readout from position 0.
REQ-007 Port stop  input  1: one-cycle pulse; end readout.
REQ-008 Port wr_pos  input  POS_BITS: writer's next-write position, driven by the writer side.
REQ-009 Port rd_addr  output  POS_BITS: address to the synchronous RAM; always equals rd_pos.
REQ-010 Port rd_data  input  DATA_BITS: RAM read data, valid one cycle after rd_addr.
REQ-011 Port out_valid  output  1: out_data holds an unconsumed entry.
REQ-012 Port out_ready  input  1: consumer accepts out_data.
REQ-013 Port out_data  output  DATA_BITS: registered entry.
REQ-014 Port rd_pos  output  POS_BITS: current read position.
REQ-015 Port busy  output  1: high in every state except IDLE.
REQ-016 Port empty  output  1: combinational (rd_pos == wr_pos).

Function
REQ-017 The FSM SHALL have four states: IDLE, FETCH, LATCH, PRESENT.
REQ-018 IDLE: start=1 and stop=0 -> clear rd_pos to 0, go to FETCH; otherwise stay in IDLE.
REQ-019 FETCH: empty=1 -> stay in FETCH and keep out_valid=0; empty=0 -> go to LATCH.
REQ-020 LATCH: capture rd_data into out_data, go to PRESENT; LATCH is exactly one cycle.
REQ-021 PRESENT: drive out_valid=1.
  - out_data and out_valid SHALL remain stable until out_valid && out_ready.
  - On handshake: rd_pos advances, then FETCH, or IDLE if a stop is pending.
REQ-022 Advance rule: rd_pos == ARRAY_SIZE-1 -> 0; otherwise rd_pos+1, computed in POS_BITS width.
REQ-023 Latency: at most 3 cycles from rd_pos change (non-empty) to out_valid=1 (FETCH, LATCH, PRESENT).
REQ-024 stop in FETCH or LATCH -> IDLE next cycle, with no out_valid asserted for that entry.
REQ-025 stop in PRESENT SHALL set stop_pending.
  - The current entry is still presented.
  - On handshake: advance rd_pos, go to IDLE, clear stop_pending.
REQ-026 stop in IDLE SHALL be ignored.
REQ-027 start while busy SHALL be ignored.
REQ-028 start and stop asserted in the same cycle in IDLE: stop wins and the FSM stays in IDLE.
REQ-029 wr_pos changing during LATCH or PRESENT SHALL NOT affect the entry being presented.
REQ-030 out_valid SHALL be registered (state == PRESENT); no combinational path from out_ready to out_valid.

Reset
REQ-031 While rst_n=0, within the same cycle:
  - state = IDLE, rd_pos = 0, out_data = 0, stop_pending = 0;
  - out_valid = 0, busy = 0.
REQ-032 Reset asserted mid-operation SHALL abort immediately; the consumer sees out_valid fall with no handshake.
REQ-033 Reset deassertion SHALL require no further initialisation; the next start is honoured.

Structure
REQ-034 Shared package: FSM state encoding constants (2 bits: IDLE=0, FETCH=1, LATCH=2, PRESENT=3).
REQ-035 One sub-module, ring_rd_pos, SHALL hold rd_pos.
  - Ports: async active-low reset, synchronous clear, enable.
  - Wrap at ARRAY_SIZE-1.
REQ-036 The RAM is external to this block.

Verification (ARRAY_SIZE=5, POS_BITS=3, DATA_BITS=8; RAM[i] = 8'h10+i)
REQ-037 Basic readout:
  - Stimulus: wr_pos=3, start, out_ready=1.
  - Response: out_data 10, 11, 12, each accepted; then FETCH with rd_pos=3, empty=1, out_valid=0.
REQ-038 Wrap:
  - Stimulus: writer fills and wraps to wr_pos=2; consumer reads 7 entries.
  - Response: sequence 10..14, 10, 11; rd_pos goes 4 -> 0.
REQ-039 Backpressure:
  - Stimulus: out_ready=0 for 6 cycles in PRESENT.
  - Response: out_valid=1 and out_data=10 constant; rd_pos stays 0 until out_ready=1.
REQ-040 Stop pending:
  - Stimulus: stop during PRESENT (rd_pos=1), out_ready=0, then out_ready=1 two cycles later.
  - Response: 11 accepted; state IDLE; rd_pos=2; busy=0.
REQ-041 Simultaneous events and reset:
  - start+stop in IDLE -> stays IDLE.
  - rst_n=0 in LATCH -> out_valid=0, rd_pos=0, state IDLE in the same cycle.
